// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: address/instruction widths,
// reset vector, fetch stride and the {pc, instr} record carried by the fetch queue.
package mips_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int PC_INC  = 2;
  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle of the fetch stage: redirect input from the core, the instruction
// memory request/response channels, the downstream instruction stream and the
// debug PC. master = fetch unit side, slave = core/memory side.
interface fetch_unit_if;
  import mips_pkg::*;

  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [PC_W-1:0]    PC;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, PC
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, PC
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries. A pop in the same cycle as flush
// is simply absorbed by the flush; flush also wins over push.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign o_head = r_mem[r_rd_ptr];

  // Entry storage: written at the tail, no reset needed since empty masks it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential fetch addresses under a credit
// limit (queue occupancy + requests in flight never exceeds DEPTH), tags
// in-order responses with their PC, and drops responses that belong to the
// stream abandoned by a redirect.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CREDIT = (CW + 1)'(DEPTH);

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_occ;
  logic [CW:0]     w_inflight;
  logic            w_full;
  logic            w_empty;
  logic            w_req_valid;
  logic            w_issue;
  logic            w_rsp_ok;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_head;
  fetch_entry_t    w_new;

  // Request is held low while in reset so nothing leaks out before the first edge.
  assign w_inflight  = {1'b0, w_occ} + {1'b0, r_outstanding};
  assign w_req_valid = rst_n && !bus.redirect_valid && (w_inflight < CREDIT);
  assign w_issue     = w_req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_ok    = bus.imem_rsp_valid && (r_outstanding != '0);
  assign w_push      = w_rsp_ok && (r_drop_cnt == '0) && !bus.redirect_valid && !w_full;
  assign w_pop       = !w_empty && bus.out_ready;
  assign w_new       = '{pc: r_rsp_pc, instr: bus.imem_rsp_data};

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.PC             = r_fetch_pc;
  assign bus.out_valid      = !w_empty;
  assign bus.out_instr      = w_empty ? '0 : w_head.instr;
  assign bus.out_pc         = w_empty ? '0 : w_head.pc;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (w_push),
    .pop    (w_pop),
    .flush  (bus.redirect_valid),
    .i_data (w_new),
    .o_head (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_occ)
  );

  // Fetch address: restart on redirect, otherwise advance on each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_fetch_pc <= RESET_PC;
    else if (bus.redirect_valid) r_fetch_pc <= bus.redirect_pc;
    else if (w_issue)            r_fetch_pc <= r_fetch_pc + PC_W'(PC_INC);
  end

  // PC tag for the next kept response; follows the fetch stream in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_rsp_pc <= RESET_PC;
    else if (bus.redirect_valid) r_rsp_pc <= bus.redirect_pc;
    else if (w_push)             r_rsp_pc <= r_rsp_pc + PC_W'(PC_INC);
  end

  // Requests in flight: +1 per issue, -1 per legal response (no issue during redirect).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_outstanding <= '0;
    else        r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_rsp_ok);
  end

  // Stale responses still to discard; a redirect replaces the count because
  // outstanding already includes any earlier stale ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_drop_cnt <= '0;
    else if (bus.redirect_valid)                r_drop_cnt <= r_outstanding - CW'(w_rsp_ok);
    else if (w_rsp_ok && (r_drop_cnt != '0))    r_drop_cnt <= r_drop_cnt - CW'(1);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an instruction memory model with configurable latency,
// a stream-level reference (expected instruction queue plus in-flight request
// list with stale marks), a cycle table for the fill/stall/backpressure cases,
// directed redirect/wrap/reset sequences and a randomized phase.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] addr_m;   // address the reference expects
    logic [15:0] addr_d;   // address the DUT actually sent (memory answers this)
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  typedef struct {
    bit          rst;
    int          lat;
    bit          ready;
    bit          oready;
    bit          req_v;
    logic [15:0] addr;
    bit          out_v;
    logic [15:0] opc;
  } vec_t;

  req_t  pend[$];
  ent_t  exp_q[$];
  vec_t  vecs[$];
  logic [15:0] m_pc;
  int    cyc = 0;
  int    lat_cfg = 1;
  bit    spur = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  // captured per-cycle stimulus for the model update
  bit          m_req_v, s_redir, s_ready, s_oready, s_rsp;
  logic [15:0] s_rpc, s_addr_d;

  function automatic logic [15:0] memf(logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic void addv(bit r, int l, bit rd, bit ord, bit rv,
                               logic [15:0] a, bit ov, logic [15:0] op);
    vecs.push_back('{r, l, rd, ord, rv, a, ov, op});
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_instr"}, 32'(bus.out_instr), 0);
    chk({tag, "_out_pc"},    32'(bus.out_pc), 0);
    chk({tag, "_PC"},        32'(bus.PC), 32'(RESET_PC));
  endtask

  // Reset DUT, memory and reference; called just after a rising edge.
  task automatic do_reset(int lat);
    #1;
    rst_n = 1'b0;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.imem_req_ready = 0;
    bus.out_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    spur = 0;
    pend.delete(); exp_q.delete();
    m_pc = RESET_PC; lat_cfg = lat;
    #1;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // First half of a cycle: memory drives its response, outputs are compared
  // against the reference on the falling edge.
  task automatic cyc_begin();
    if (spur && pend.size() == 0) begin
      bus.imem_rsp_valid = 1; bus.imem_rsp_data = 16'($urandom);
    end else if (pend.size() != 0 && pend[0].due <= cyc &&
                 (lat_cfg != 0 || $urandom_range(3) != 0)) begin
      bus.imem_rsp_valid = 1; bus.imem_rsp_data = memf(pend[0].addr_d);
    end else begin
      bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    end
    @(negedge clk);
    m_req_v = !bus.redirect_valid && (exp_q.size() + pend.size() < DEPTH);
    chk("req_valid", 32'(bus.imem_req_valid), 32'(m_req_v));
    if (m_req_v) chk("req_addr", 32'(bus.imem_req_addr), 32'(m_pc));
    chk("PC", 32'(bus.PC), 32'(m_pc));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_pc", 32'(bus.out_pc), 32'(exp_q[0].pc));
      chk("out_instr", 32'(bus.out_instr), 32'(exp_q[0].instr));
    end
    s_redir = bus.redirect_valid; s_rpc = bus.redirect_pc;
    s_ready = bus.imem_req_ready; s_oready = bus.out_ready;
    s_rsp = bus.imem_rsp_valid; s_addr_d = bus.imem_req_addr;
  endtask

  // Second half: clock edge, then advance the reference by one cycle.
  task automatic cyc_end();
    req_t e;
    int   l;
    @(posedge clk);
    if (exp_q.size() != 0 && s_oready) void'(exp_q.pop_front());
    if (s_rsp && pend.size() != 0) begin
      e = pend.pop_front();
      if (!e.stale && !s_redir) exp_q.push_back('{e.addr_m, memf(e.addr_m)});
    end
    if (m_req_v && s_ready) begin
      l = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
      pend.push_back('{m_pc, s_addr_d, cyc + l, 1'b0});
      m_pc = m_pc + 16'd2;
    end
    if (s_redir) begin
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_pc = s_rpc;
    end
    cyc++;
    #1;
  endtask

  task automatic cycle();
    cyc_begin();
    cyc_end();
  endtask

  // Run until out_valid appears (bounded) and check the head PC.
  task automatic wait_head(string nm, logic [15:0] pc);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc_begin();
      if (bus.out_valid) begin
        found = 1;
        chk(nm, 32'(bus.out_pc), 32'(pc));
      end
      cyc_end();
    end
    if (!found) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst lat rdy ordy | req_v addr out_v out_pc
    // Fill: 1-cycle memory, everything ready
    addv(1, 1, 1, 1, 1, 16'h0000, 0, 16'h0000);
    addv(0, 1, 1, 1, 1, 16'h0002, 0, 16'h0000);
    addv(0, 1, 1, 1, 1, 16'h0004, 1, 16'h0000);
    addv(0, 1, 1, 1, 1, 16'h0006, 1, 16'h0002);
    addv(0, 1, 1, 1, 1, 16'h0008, 1, 16'h0004);
    addv(0, 1, 1, 1, 1, 16'h000A, 1, 16'h0006);
    // Backpressure: credit stops after 4 requests, resumes after first pop
    addv(1, 1, 1, 0, 1, 16'h0000, 0, 16'h0000);
    addv(0, 1, 1, 0, 1, 16'h0002, 0, 16'h0000);
    addv(0, 1, 1, 0, 1, 16'h0004, 1, 16'h0000);
    addv(0, 1, 1, 0, 1, 16'h0006, 1, 16'h0000);
    addv(0, 1, 1, 0, 0, 16'h0008, 1, 16'h0000);
    addv(0, 1, 1, 0, 0, 16'h0008, 1, 16'h0000);
    addv(0, 1, 1, 0, 0, 16'h0008, 1, 16'h0000);
    addv(0, 1, 1, 1, 0, 16'h0008, 1, 16'h0000);
    addv(0, 1, 1, 1, 1, 16'h0008, 1, 16'h0002);
    addv(0, 1, 1, 1, 1, 16'h000A, 1, 16'h0004);
    // Request stall: ready 1,0,0,1,1,1
    addv(1, 1, 1, 1, 1, 16'h0000, 0, 16'h0000);
    addv(0, 1, 0, 1, 1, 16'h0002, 0, 16'h0000);
    addv(0, 1, 0, 1, 1, 16'h0002, 1, 16'h0000);
    addv(0, 1, 1, 1, 1, 16'h0002, 0, 16'h0000);
    addv(0, 1, 1, 1, 1, 16'h0004, 0, 16'h0000);
    addv(0, 1, 1, 1, 1, 16'h0006, 1, 16'h0002);

    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.imem_req_ready = 0;
    bus.out_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    @(posedge clk);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset(vecs[k].lat);
      bus.imem_req_ready = vecs[k].ready;
      bus.out_ready = vecs[k].oready;
      bus.redirect_valid = 0;
      cyc_begin();
      chk($sformatf("vec%0d_req_valid", k), 32'(bus.imem_req_valid), 32'(vecs[k].req_v));
      chk($sformatf("vec%0d_addr", k), 32'(bus.imem_req_addr), 32'(vecs[k].addr));
      chk($sformatf("vec%0d_out_valid", k), 32'(bus.out_valid), 32'(vecs[k].out_v));
      if (vecs[k].out_v) begin
        chk($sformatf("vec%0d_out_pc", k), 32'(bus.out_pc), 32'(vecs[k].opc));
        chk($sformatf("vec%0d_out_instr", k), 32'(bus.out_instr), 32'(memf(vecs[k].opc)));
      end
      cyc_end();
    end

    // Redirect with two old requests in flight on a 3-cycle memory
    do_reset(3);
    bus.imem_req_ready = 1; bus.out_ready = 1;
    cycle(); cycle();
    bus.redirect_valid = 1; bus.redirect_pc = 16'h0040;
    cycle();
    bus.redirect_valid = 0;
    wait_head("redir_head0", 16'h0040);
    cyc_begin();
    chk("redir_head1_valid", 32'(bus.out_valid), 1);
    chk("redir_head1_pc", 32'(bus.out_pc), 32'h0042);
    cyc_end();

    // Redirect coinciding with a response and an output handshake
    do_reset(1);
    bus.imem_req_ready = 1; bus.out_ready = 1;
    cycle(); cycle(); cycle();
    bus.redirect_valid = 1; bus.redirect_pc = 16'h0100;
    cyc_begin();
    chk("rc_out_valid_in_R", 32'(bus.out_valid), 1);
    chk("rc_rsp_in_R", 32'(bus.imem_rsp_valid), 1);
    chk("rc_no_req_in_R", 32'(bus.imem_req_valid), 0);
    cyc_end();
    bus.redirect_valid = 0;
    cyc_begin();
    chk("rc_out_valid_R1", 32'(bus.out_valid), 0);
    chk("rc_req_valid_R1", 32'(bus.imem_req_valid), 1);
    chk("rc_addr_R1", 32'(bus.imem_req_addr), 32'h0100);
    cyc_end();
    wait_head("rc_head", 16'h0100);

    // Spurious response with nothing outstanding is ignored
    do_reset(1);
    bus.imem_req_ready = 1; bus.out_ready = 1;
    spur = 1;
    cyc_begin();
    spur = 0;
    cyc_end();
    cyc_begin();
    chk("spur_out_valid", 32'(bus.out_valid), 0);
    cyc_end();
    wait_head("spur_head", 16'h0000);

    // Address wrap, then asynchronous reset mid-stream
    do_reset(1);
    bus.imem_req_ready = 1; bus.out_ready = 1;
    bus.redirect_valid = 1; bus.redirect_pc = 16'hFFFE;
    cycle();
    bus.redirect_valid = 0;
    cyc_begin();
    chk("wrap_addr0", 32'(bus.imem_req_addr), 32'hFFFE);
    cyc_end();
    cyc_begin();
    chk("wrap_addr1", 32'(bus.imem_req_addr), 32'h0000);
    cyc_end();
    cyc_begin();
    chk("wrap_out_pc0", 32'(bus.out_pc), 32'hFFFE);
    cyc_end();
    cyc_begin();
    chk("wrap_out_pc1", 32'(bus.out_pc), 32'h0000);
    cyc_end();
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(posedge clk);
    do_reset(1);

    // Randomized traffic: random latency, stalls, redirects, resets
    do_reset(0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(499) == 0) do_reset(0);
      bus.imem_req_ready = ($urandom_range(9) < 7);
      bus.out_ready      = ($urandom_range(9) < 7);
      bus.redirect_valid = ($urandom_range(24) == 0);
      bus.redirect_pc    = 16'($urandom) & 16'hFFFE;
      spur               = ($urandom_range(49) == 0);
      cycle();
    end
    spur = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
